// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding, bus width
// and the frame acceptance rule.
package ps2_kbd_rx_pkg;

  localparam int KBD_DATA_BUS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_ok(input logic [KBD_DATA_BUS-1:0] data,
                                    input logic parity, input logic stop);
    return ((^data) ^ parity) & stop;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/count; a push while full
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wptr_reg;
  logic [AW:0]   rptr_reg;
  logic          pop_ok;
  logic          push_ok;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count    = wptr_reg - rptr_reg;
  assign rd_valid = (count != '0);
  assign full     = count[AW];
  assign pop_ok   = pop & rd_valid;
  assign push_ok  = push & (~full | pop_ok);
  assign rd_data  = rd_valid ? mem[rptr_reg[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + 1'b1;
      if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: oversamples PS2_CLK/PS2_DAT on the system clock,
// checks each 11-bit frame and queues good scancodes in a FWFT FIFO.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ps2_clk,
  input  logic                    ps2_dat,
  input  logic                    rd_en,
  output logic [KBD_DATA_BUS-1:0] rd_data,
  output logic                    rd_valid,
  output logic [FIFO_AW:0]        count,
  input  logic                    clr_err,
  output logic                    overflow,
  output logic                    frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]              clk_sync_reg;
  logic [1:0]              dat_sync_reg;
  logic                    clk_prev_reg;
  logic                    fall_edge;
  logic                    dat_s;
  ps2_state_t              state_reg;
  logic [2:0]              bit_cnt_reg;
  logic [KBD_DATA_BUS-1:0] shreg_reg;
  logic                    parity_reg;
  logic [TW-1:0]           idle_cnt_reg;
  logic                    stop_edge;
  logic                    push;
  logic                    frame_bad;
  logic                    fifo_full;
  logic                    drop;
  logic                    overflow_reg;
  logic                    frame_err_reg;

  // Synchronizers reset high so an idle bus produces no spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_reg <= 2'b11;
      dat_sync_reg <= 2'b11;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[0], ps2_clk};
      dat_sync_reg <= {dat_sync_reg[0], ps2_dat};
      clk_prev_reg <= clk_sync_reg[1];
    end
  end

  assign fall_edge = clk_prev_reg & ~clk_sync_reg[1];
  assign dat_s     = dat_sync_reg[1];
  assign stop_edge = fall_edge && (state_reg == ST_STOP);
  assign push      = stop_edge && frame_ok(shreg_reg, parity_reg, dat_s);
  assign frame_bad = stop_edge && !frame_ok(shreg_reg, parity_reg, dat_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      shreg_reg    <= '0;
      parity_reg   <= 1'b0;
      idle_cnt_reg <= '0;
    end else begin
      if (fall_edge || state_reg == ST_IDLE) idle_cnt_reg <= '0;
      else                                   idle_cnt_reg <= idle_cnt_reg + 1'b1;

      if (fall_edge) begin
        case (state_reg)
          ST_IDLE: begin
            if (!dat_s) begin
              state_reg   <= ST_DATA;
              bit_cnt_reg <= '0;
            end
          end
          ST_DATA: begin
            shreg_reg   <= {dat_s, shreg_reg[KBD_DATA_BUS-1:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) state_reg <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_reg <= dat_s;
            state_reg  <= ST_STOP;
          end
          ST_STOP:  state_reg <= ST_IDLE;
          default:  state_reg <= ST_IDLE;
        endcase
      end else if (state_reg != ST_IDLE && idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        // Stalled frame: drop the partial byte silently.
        state_reg <= ST_IDLE;
      end
    end
  end

  assign drop = push & fifo_full & ~(rd_en & rd_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (drop)         overflow_reg  <= 1'b1;
      else if (clr_err) overflow_reg  <= 1'b0;
      if (frame_bad)    frame_err_reg <= 1'b1;
      else if (clr_err) frame_err_reg <= 1'b0;
    end
  end

  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;

  sync_fifo #(
    .DW (KBD_DATA_BUS),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg_reg),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (fifo_full),
    .count     (count)
  );

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Receives PS/2 keyboard frames (device-to-host only) from the board PS2_CLK/PS2_DAT pins.
- Checks each 11-bit frame and buffers the resulting scancodes in a small FIFO.
- Sits directly upstream of the peripheral bus block, which reads scancodes through a pop handshake when the core loads the keyboard address.
- Fully synchronous to the 50 MHz system clock; the PS/2 clock is sampled as data and is never used as a clock.

Parameters:
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8 entries.
- TIMEOUT_CYCLES, 50000: idle clk cycles mid-frame before the frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin (asynchronous).
- ps2_dat  input  1  raw PS/2 data pin (asynchronous).
- rd_en  input  1  pop request from the peripheral bus.
- rd_data  output  8  head-of-FIFO scancode (first-word-fall-through).
- rd_valid  output  1  FIFO non-empty.
- count  output  FIFO_AW+1  number of entries held.
- clr_err  input  1  clears the sticky error flags.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: parity error or bad stop bit.

Behaviour:
- Reset (async, active-high): FSM to IDLE; FIFO pointers to 0; rd_valid=0; count=0; rd_data=0x00; overflow=0; frame_err=0; synchronizers to 1 (bus idle-high).
- Input capture: ps2_clk and ps2_dat each pass through a 2-flop synchronizer. A falling-edge pulse fires when the registered previous synced clock is 1 and the current is 0.
- Edge latency: the edge pulse occurs 3 clk cycles after the pin falls. Data is sampled from the synced ps2_dat in the same cycle as the pulse.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions happen only on an edge pulse, except timeout.
  - IDLE: on an edge with dat=0 (start bit), go to DATA with bit_cnt=0. On an edge with dat=1, stay in IDLE; this is not flagged.
  - DATA: shift the bit into the shift register LSB-first (shreg <= {dat, shreg[7:1]}) and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: the frame is good if ^data ^ parity == 1 (odd parity) and dat=1. A good frame pushes the byte; otherwise frame_err is set and nothing is pushed. Go to IDLE in either case.
- Push timing: the push happens on the clk edge that ends the STOP-edge-pulse cycle. rd_valid and count update on that same edge, so they are visible the next cycle.
- Timeout: a counter clears on every edge pulse and counts while state != IDLE. At TIMEOUT_CYCLES-1 the FSM returns to IDLE, the partial byte is discarded, and no flag is set.
- Pop: when rd_en=1 and rd_valid=1, the read pointer advances at the clk edge. rd_en while empty is ignored and has no side effects.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - When full, this case is not an overflow.
  - When empty, the push must not be lost (rd_valid goes to 1 next cycle).
- Full: a push with no pop is dropped, FIFO contents are unchanged, and overflow=1.
- Flag clearing: clr_err clears overflow and frame_err on the next edge. If clr_err coincides with a new error event, the set wins.
- Pointers are FIFO_AW+1 bits with natural wrap; count = wptr - rptr.
- No rst other than the pin: an async rst mid-frame aborts the frame and empties the FIFO.

Decomposition:
- Shared definitions (common.v):
  - PS/2 FSM state encodings (2 bits).
  - `KBD_DATA_BUS` byte width, for reuse by the peripheral bus address decode.
- Sub-module `sync_fifo`, parameterized by data width and AW, with FWFT output and full/empty/count. It is reusable for the UART later.
- Synchronizers and the FSM stay inline.

Test Plan:
- Frame 0x1C: bits 0,0,1,1,1,0,0,0, parity 0, stop 1, at a 60 us bit period -> rd_valid=1, rd_data=0x1C, count=1, no flags.
- Frames 0xF0 (parity 1) then 0x1C, then rd_en pulses -> rd_data reads 0xF0 then 0x1C; count goes 2,1,0; rd_valid=0 afterwards.
- Frame 0x29 with parity bit inverted -> frame_err=1, count unchanged. Then clr_err pulse -> frame_err=0. A good 0x29 is then received.
- Nine frames 0x01..0x09 with no reads -> count=8, overflow=1, rd_data=0x01. A pop concurrent with a tenth push -> count stays 8 and no additional drop.
- Start bit plus 3 data bits, then silence for 50000 cycles -> FSM back in IDLE, no push, no flag. The next frame 0x5A is received correctly.
- rst asserted mid-frame with 2 bytes buffered -> all outputs return to their reset values at once. The remainder of the interrupted frame does not cause a push.
